qpu_exu_tevq: RTL and testbench

//  Consumer end of the EXU ALU time/event write-back channels (twbck/ewbck).

---
 rtl/qpu_exu_tevq_pkg.sv | 10 +
 rtl/qpu_sync_fifo.sv | 40 ++++
 rtl/qpu_exu_tevq.sv | 81 ++++++++
 tb/tb_qpu_exu_tevq.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/qpu_exu_tevq_pkg.sv
// qpu_exu_tevq_pkg: shared widths and FSM encodings for the EXU time/event queue
package qpu_exu_tevq_pkg;
  localparam int TIME_W_DEF = 32;
  localparam int EDATA_W_DEF = 24;
  localparam int ENUM_W_DEF = 3;
  localparam int DEPTH_DEF = 8;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
endpackage

// File: rtl/qpu_sync_fifo.sv
// qpu_sync_fifo: synchronous first-word-fall-through FIFO with registered count
module qpu_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic do_push, do_pop;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign do_push = push & ~full;
  assign do_pop = pop & ~empty;
  assign rdata = mem[rp];
  always_ff @(posedge clk) begin
    if (rst | clr) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop) rp <= rp + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= wdata;
  end
endmodule

// File: rtl/qpu_exu_tevq.sv
// qpu_exu_tevq: stamps QI events with the QWAIT timeline and issues them when due
module qpu_exu_tevq
  import qpu_exu_tevq_pkg::*;
#(
  parameter int TIME_W = TIME_W_DEF,
  parameter int EDATA_W = EDATA_W_DEF,
  parameter int ENUM_W = ENUM_W_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    twbck_i_valid,
  output logic                    twbck_i_ready,
  input  logic [TIME_W-1:0]       twbck_i_data,
  input  logic                    ewbck_i_valid,
  output logic                    ewbck_i_ready,
  input  logic [EDATA_W-1:0]      ewbck_i_data,
  input  logic [ENUM_W-1:0]       ewbck_i_oprand,
  input  logic                    start,
  input  logic                    stop,
  input  logic                    flush,
  output logic                    evt_o_valid,
  input  logic                    evt_o_ready,
  output logic [EDATA_W-1:0]      evt_o_data,
  output logic [ENUM_W-1:0]       evt_o_oprand,
  output logic                    evt_o_late,
  output logic                    late_sticky,
  output logic [$clog2(DEPTH):0]  q_count,
  output logic                    busy
);
  logic [1:0] state;
  logic [TIME_W-1:0] tl, tmr, tl_sum, stamp, head_stamp, elapsed;
  logic [EDATA_W-1:0] head_data;
  logic [ENUM_W-1:0] head_opr;
  logic full, empty, tw_hs, ew_hs, pop;
  assign twbck_i_ready = ~flush & (state != ST_DRAIN);
  assign ewbck_i_ready = twbck_i_ready & ~full;
  assign tw_hs = twbck_i_valid & twbck_i_ready;
  assign ew_hs = ewbck_i_valid & ewbck_i_ready;
  assign tl_sum = tl + twbck_i_data;
  assign stamp = tw_hs ? tl_sum : tl;
  // MSB of the modular difference gives a wrap-safe "stamp <= tmr"
  assign elapsed = tmr - head_stamp;
  assign evt_o_valid = ~empty & ~elapsed[TIME_W-1] & (state != ST_IDLE);
  assign evt_o_data = evt_o_valid ? head_data : '0;
  assign evt_o_oprand = evt_o_valid ? head_opr : '0;
  assign pop = evt_o_valid & evt_o_ready;
  assign evt_o_late = pop & (tmr != head_stamp);
  assign busy = state != ST_IDLE;
  qpu_sync_fifo #(.WIDTH(TIME_W+EDATA_W+ENUM_W), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .clr(flush),
    .push(ew_hs),
    .pop(pop),
    .wdata({stamp, ewbck_i_data, ewbck_i_oprand}),
    .rdata({head_stamp, head_data, head_opr}),
    .count(q_count),
    .full(full),
    .empty(empty)
  );
  always_ff @(posedge clk) begin
    if (rst | flush) begin
      state <= ST_IDLE;
      tl <= '0;
      tmr <= '0;
      late_sticky <= 1'b0;
    end else begin
      if (tw_hs) tl <= tl_sum;
      if (state != ST_IDLE) tmr <= tmr + 1'b1;
      if (evt_o_late) late_sticky <= 1'b1;
      if (state == ST_IDLE && start) state <= ST_RUN;
      if (state == ST_RUN && stop) state <= ST_DRAIN;
      if (state == ST_DRAIN && empty) begin
        state <= ST_IDLE;
        tl <= '0;
        tmr <= '0;
      end
    end
  end
endmodule

// File: tb/tb_qpu_exu_tevq.sv
// tb_qpu_exu_tevq: directed scenarios plus random traffic against a queue-based model
module tb_qpu_exu_tevq;
  localparam int TW = 8;
  localparam int DW = 24;
  localparam int OW = 3;
  localparam int DEPTH = 8;
  localparam int CW = 4;
  logic clk = 0, rst = 1;
  logic twbck_i_valid = 0, twbck_i_ready;
  logic [TW-1:0] twbck_i_data = 0;
  logic ewbck_i_valid = 0, ewbck_i_ready;
  logic [DW-1:0] ewbck_i_data = 0;
  logic [OW-1:0] ewbck_i_oprand = 0;
  logic start = 0, stop = 0, flush = 0;
  logic evt_o_valid, evt_o_ready = 1;
  logic [DW-1:0] evt_o_data;
  logic [OW-1:0] evt_o_oprand;
  logic evt_o_late, late_sticky, busy;
  logic [CW-1:0] q_count;
  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  qpu_exu_tevq #(.TIME_W(TW), .EDATA_W(DW), .ENUM_W(OW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .twbck_i_valid(twbck_i_valid), .twbck_i_ready(twbck_i_ready), .twbck_i_data(twbck_i_data),
    .ewbck_i_valid(ewbck_i_valid), .ewbck_i_ready(ewbck_i_ready), .ewbck_i_data(ewbck_i_data),
    .ewbck_i_oprand(ewbck_i_oprand), .start(start), .stop(stop), .flush(flush),
    .evt_o_valid(evt_o_valid), .evt_o_ready(evt_o_ready), .evt_o_data(evt_o_data),
    .evt_o_oprand(evt_o_oprand), .evt_o_late(evt_o_late), .late_sticky(late_sticky),
    .q_count(q_count), .busy(busy)
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: list of pending events, a mode number, and two plain counters
  typedef struct {
    logic [TW-1:0] s;
    logic [DW-1:0] d;
    logic [OW-1:0] o;
  } ent_t;
  ent_t mq[$];
  ent_t mh, me;
  int mode;
  logic [TW-1:0] mtl, mtmr, mel, mns;
  logic msticky, e_trdy, e_erdy, e_val, e_late, m_was_empty;

  always @(negedge clk) begin
    if (rst) begin
      mq.delete();
      mode = 0;
      mtl = 0;
      mtmr = 0;
      msticky = 0;
    end else begin
      e_trdy = !flush && mode != 2;
      e_erdy = e_trdy && mq.size() < DEPTH;
      e_val = 0;
      mh = '{s: 0, d: 0, o: 0};
      if (mq.size() > 0) begin
        mh = mq[0];
        mel = mtmr - mh.s;
        e_val = mode != 0 && int'(mel) < (1 << (TW - 1));
      end
      e_late = e_val && evt_o_ready && mtmr != mh.s;
      check("tw_ready", twbck_i_ready, e_trdy);
      check("ew_ready", ewbck_i_ready, e_erdy);
      check("evt_valid", evt_o_valid, e_val);
      check("evt_data", evt_o_data, e_val ? mh.d : 0);
      check("evt_oprand", evt_o_oprand, e_val ? mh.o : 0);
      check("evt_late", evt_o_late, e_late);
      check("late_sticky", late_sticky, msticky);
      check("q_count", q_count, mq.size());
      check("busy", busy, mode != 0);
      if (flush) begin
        mq.delete();
        mode = 0;
        mtl = 0;
        mtmr = 0;
        msticky = 0;
      end else begin
        m_was_empty = mq.size() == 0;
        mns = (twbck_i_valid && e_trdy) ? mtl + twbck_i_data : mtl;
        if (e_val && evt_o_ready) me = mq.pop_front();
        if (ewbck_i_valid && e_erdy) begin
          me.s = mns;
          me.d = ewbck_i_data;
          me.o = ewbck_i_oprand;
          mq.push_back(me);
        end
        mtl = mns;
        if (e_late) msticky = 1;
        if (mode != 0) mtmr = mtmr + 1;
        if (mode == 0 && start) mode = 1;
        else if (mode == 1 && stop) mode = 2;
        else if (mode == 2 && m_was_empty) begin
          mode = 0;
          mtl = 0;
          mtmr = 0;
        end
      end
    end
  end

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    check("rst_tw_ready", twbck_i_ready, 1);
    check("rst_ew_ready", ewbck_i_ready, 1);
    check("rst_valid", evt_o_valid, 0);
    check("rst_q_count", q_count, 0);
    check("rst_busy", busy, 0);
    check("rst_sticky", late_sticky, 0);
    // stamp from same-cycle QWAIT, due at tmr=5
    start = 1; step(); start = 0;
    twbck_i_valid = 1; twbck_i_data = 5; ewbck_i_valid = 1; ewbck_i_data = 24'h0a0a0a; ewbck_i_oprand = 3'b101;
    step();
    twbck_i_valid = 0; ewbck_i_valid = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); check("t1_early", evt_o_valid, 0); step();
    end
    @(negedge clk);
    check("t1_valid", evt_o_valid, 1);
    check("t1_data", evt_o_data, 24'h0a0a0a);
    check("t1_oprand", evt_o_oprand, 3'b101);
    check("t1_late", evt_o_late, 0);
    step();
    // backpressure at due: stamp 7, held for 3 cycles, issued late
    twbck_i_valid = 1; twbck_i_data = 2; ewbck_i_valid = 1; ewbck_i_data = 24'h0b0b0b; ewbck_i_oprand = 3'b010;
    evt_o_ready = 0;
    step();
    twbck_i_valid = 0; ewbck_i_valid = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("t2_hold_valid", evt_o_valid, 1);
      check("t2_hold_data", evt_o_data, 24'h0b0b0b);
      step();
    end
    evt_o_ready = 1;
    @(negedge clk); check("t2_late", evt_o_late, 1);
    step();
    @(negedge clk); check("t2_sticky", late_sticky, 1);
    // fill the queue; a pop does not free a slot in the same cycle
    evt_o_ready = 0; ewbck_i_valid = 1;
    for (int i = 0; i < DEPTH; i++) begin
      ewbck_i_data = 24'(i + 16); step();
    end
    evt_o_ready = 1;
    @(negedge clk);
    check("t3_full_count", q_count, DEPTH);
    check("t3_full_ready", ewbck_i_ready, 0);
    check("t3_full_valid", evt_o_valid, 1);
    step();
    ewbck_i_valid = 0;
    @(negedge clk); check("t3_after_pop", q_count, DEPTH - 1);
    n = 0;
    while (q_count != 0 && n < 40) begin step(); n++; end
    check("t3_drained", q_count, 0);
    // wrap: tl=254, +4 -> stamp 2; tmr crosses 255->0 before issue
    flush = 1; step(); flush = 0;
    @(negedge clk);
    check("t4_flush_busy", busy, 0);
    check("t4_flush_sticky", late_sticky, 0);
    twbck_i_valid = 1; twbck_i_data = 254; step(); twbck_i_valid = 0;
    start = 1; step(); start = 0;
    repeat (250) step();
    twbck_i_valid = 1; twbck_i_data = 4; ewbck_i_valid = 1; ewbck_i_data = 24'h0c0c0c; ewbck_i_oprand = 3'b111;
    step();
    twbck_i_valid = 0; ewbck_i_valid = 0;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk); check("t4_not_due", evt_o_valid, 0); step();
    end
    @(negedge clk);
    check("t4_valid", evt_o_valid, 1);
    check("t4_data", evt_o_data, 24'h0c0c0c);
    check("t4_late", evt_o_late, 0);
    step();
    // stop with three queued: drain then IDLE with cleared timeline
    evt_o_ready = 0; ewbck_i_valid = 1;
    for (int i = 0; i < 3; i++) begin
      ewbck_i_data = 24'(i + 32); step();
    end
    ewbck_i_valid = 0;
    stop = 1;
    @(negedge clk); check("t5_queued", q_count, 3);
    step();
    stop = 0; evt_o_ready = 1;
    @(negedge clk);
    check("t5_tw_ready", twbck_i_ready, 0);
    check("t5_ew_ready", ewbck_i_ready, 0);
    check("t5_busy", busy, 1);
    n = 0;
    while (busy && n < 20) begin step(); n++; end
    check("t5_idle", busy, 0);
    check("t5_cycles", n, 4);
    check("t5_empty", q_count, 0);
    ewbck_i_valid = 1; ewbck_i_data = 24'h0e0e0e; step(); ewbck_i_valid = 0;
    start = 1; step(); start = 0;
    @(negedge clk);
    check("t5_preload_valid", evt_o_valid, 1);
    check("t5_preload_data", evt_o_data, 24'h0e0e0e);
    check("t5_preload_late", evt_o_late, 0);
    step();
    // flush in DRAIN with two queued and an offered event
    evt_o_ready = 0; twbck_i_valid = 1; twbck_i_data = 100; ewbck_i_valid = 1;
    step();
    twbck_i_valid = 0;
    step();
    ewbck_i_valid = 0; stop = 1; step(); stop = 0;
    flush = 1; ewbck_i_valid = 1;
    @(negedge clk);
    check("t6_ew_ready", ewbck_i_ready, 0);
    check("t6_pre_count", q_count, 2);
    check("t6_pre_sticky", late_sticky, 1);
    step();
    flush = 0; ewbck_i_valid = 0; evt_o_ready = 1;
    @(negedge clk);
    check("t6_busy", busy, 0);
    check("t6_count", q_count, 0);
    check("t6_sticky", late_sticky, 0);
    // random traffic, checked every cycle by the model
    repeat (3000) begin
      twbck_i_valid = $urandom_range(3) == 0;
      twbck_i_data = TW'($urandom_range(3));
      ewbck_i_valid = $urandom_range(1) == 0;
      ewbck_i_data = DW'($urandom);
      ewbck_i_oprand = OW'($urandom);
      evt_o_ready = $urandom_range(3) != 0;
      start = $urandom_range(15) == 0;
      stop = $urandom_range(39) == 0;
      flush = $urandom_range(149) == 0;
      step();
    end
    {twbck_i_valid, ewbck_i_valid, start, stop, flush} = '0;
    step();
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
